// File: rtl/rx_fifo_pkg.sv
// rx_fifo_pkg: shared constants, UART register map and FIFO operation decode for the rx_fifo slice
package rx_fifo_pkg;
  localparam int RX_FIFO_DEPTH = 16;
  typedef enum logic [3:0] {
    TX_RDY = 4'h0,
    TX_DAT = 4'h1,
    RX_RDY = 4'h2,
    RX_DAT = 4'h3,
    RX_CNT = 4'h4,
    RX_ERR = 4'h5
  } uart_reg_e;
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_BOTH,
    OP_BYPASS,
    OP_DROP
  } fifo_op_e;
  // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
  function automatic fifo_op_e fifo_op(input logic wr, input logic rd, input logic empty, input logic full);
    return (wr & rd & empty) ? OP_BYPASS :
           (wr & rd)         ? OP_BOTH   :
           (wr & full)       ? OP_DROP   :
           wr                ? OP_PUSH   :
           (rd & !empty)     ? OP_POP    : OP_IDLE;
  endfunction
endpackage

// File: rtl/rx_fifo_if.sv
// rx_fifo_if: producer/consumer bus of the receive FIFO
interface rx_fifo_if #(parameter int DEPTH = 16);
  localparam int ADDR_W = $clog2(DEPTH);
  logic              i_wr;
  logic [7:0]        i_data;
  logic              i_rd;
  logic              i_clr_ovr;
  logic [7:0]        o_data;
  logic              o_empty;
  logic              o_full;
  logic [ADDR_W:0]   o_count;
  logic              o_overrun;
  modport slave (
    input  i_wr, i_data, i_rd, i_clr_ovr,
    output o_data, o_empty, o_full, o_count, o_overrun
  );
  modport master (
    output i_wr, i_data, i_rd, i_clr_ovr,
    input  o_data, o_empty, o_full, o_count, o_overrun
  );
endinterface

// File: rtl/rx_fifo_mem.sv
// rx_fifo_mem: DEPTH x 8 storage with one sync write port and one registered read port
module rx_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end
  // Same-address read and write return the old byte, which is what a full FIFO pop needs.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_rdata <= 8'h00;
    else if (i_re) o_rdata <= mem[i_raddr];
  end
endmodule

// File: rtl/rx_fifo.sv
// rx_fifo: byte FIFO between serial_rx and the UART register interface, with bypass and sticky overrun
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH
) (
  input  logic     i_clk,
  input  logic     i_rst,
  rx_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_nxt;
  logic [7:0]        mem_q, byp_q;
  logic              empty_q, full_q, overrun, sel_byp;
  logic              wr_en, rd_en, bypass, drop;
  fifo_op_e          op;
  always_comb begin
    op        = fifo_op(bus.i_wr, bus.i_rd, empty_q, full_q);
    wr_en     = (op == OP_PUSH) || (op == OP_BOTH);
    rd_en     = (op == OP_POP) || (op == OP_BOTH);
    bypass    = op == OP_BYPASS;
    drop      = op == OP_DROP;
    count_nxt = (op == OP_PUSH) ? count + CNT_ONE :
                (op == OP_POP)  ? count - CNT_ONE : count;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      overrun <= 1'b0;
      sel_byp <= 1'b0;
      byp_q   <= 8'h00;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      empty_q <= count_nxt == '0;
      full_q  <= count_nxt == FULL_CNT;
      overrun <= drop | (overrun & ~bus.i_clr_ovr);
      if (bypass) byp_q <= bus.i_data;
      if (bypass | rd_en) sel_byp <= bypass;
    end
  end
  rx_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (wr_en),
    .i_waddr (wr_ptr),
    .i_wdata (bus.i_data),
    .i_re    (rd_en),
    .i_raddr (rd_ptr),
    .o_rdata (mem_q)
  );
  // o_data follows whichever source delivered the most recent successful pop.
  assign bus.o_data    = sel_byp ? byp_q : mem_q;
  assign bus.o_empty   = empty_q;
  assign bus.o_full    = full_q;
  assign bus.o_count   = count;
  assign bus.o_overrun = overrun;
endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed self-checking bench for rx_fifo
module tb_rx_fifo;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int checks = 0;
  int errors = 0;
  rx_fifo_if #(.DEPTH(16)) bus ();
  rx_fifo #(.DEPTH(16)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    bus.i_wr = 1'b1;
    bus.i_data = d;
    step();
    bus.i_wr = 1'b0;
  endtask
  task automatic pop();
    bus.i_rd = 1'b1;
    step();
    bus.i_rd = 1'b0;
  endtask
  initial begin
    bus.i_wr = 1'b0;
    bus.i_rd = 1'b0;
    bus.i_data = 8'h00;
    bus.i_clr_ovr = 1'b0;
    step();
    step();
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pop();
      check("t1_data", bus.o_data, 8'h00);
      check("t1_empty", bus.o_empty, 1);
      check("t1_count", bus.o_count, 0);
      check("t1_ovr", bus.o_overrun, 0);
    end
    push(8'h41);
    check("t2_cnt1", bus.o_count, 1);
    check("t2_empty", bus.o_empty, 0);
    push(8'h42);
    push(8'h43);
    check("t2_cnt3", bus.o_count, 3);
    for (int i = 0; i < 3; i++) begin
      pop();
      check("t2_data", bus.o_data, 8'h41 + i);
      check("t2_cnt", bus.o_count, 2 - i);
    end
    check("t2_empty_end", bus.o_empty, 1);
    for (int i = 0; i < 17; i++) begin
      bus.i_clr_ovr = (i == 16);
      push(8'(i));
      if (i == 15) begin
        check("t3_full", bus.o_full, 1);
        check("t3_cnt16", bus.o_count, 16);
        check("t3_no_ovr", bus.o_overrun, 0);
      end
    end
    bus.i_clr_ovr = 1'b0;
    check("t3_ovr_set_wins", bus.o_overrun, 1);
    check("t3_cnt_drop", bus.o_count, 16);
    for (int i = 0; i < 16; i++) begin
      pop();
      check("t3_data", bus.o_data, i);
    end
    check("t3_empty", bus.o_empty, 1);
    check("t3_ovr_sticky", bus.o_overrun, 1);
    bus.i_clr_ovr = 1'b1;
    step();
    bus.i_clr_ovr = 1'b0;
    check("t3_ovr_clr", bus.o_overrun, 0);
    bus.i_wr = 1'b1;
    bus.i_rd = 1'b1;
    bus.i_data = 8'h7E;
    step();
    bus.i_wr = 1'b0;
    bus.i_rd = 1'b0;
    check("t4_byp_data", bus.o_data, 8'h7E);
    check("t4_byp_cnt", bus.o_count, 0);
    check("t4_byp_empty", bus.o_empty, 1);
    pop();
    check("t4_hold", bus.o_data, 8'h7E);
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    bus.i_wr = 1'b1;
    bus.i_rd = 1'b1;
    bus.i_data = 8'hAA;
    step();
    bus.i_wr = 1'b0;
    bus.i_rd = 1'b0;
    check("t5_full_data", bus.o_data, 8'h10);
    check("t5_full_ovr", bus.o_overrun, 0);
    check("t5_full_cnt", bus.o_count, 16);
    check("t5_full_flag", bus.o_full, 1);
    for (int i = 1; i < 16; i++) begin
      pop();
      check("t5_data", bus.o_data, 8'h10 + i);
    end
    pop();
    check("t5_last", bus.o_data, 8'hAA);
    check("t5_empty", bus.o_empty, 1);
    for (int i = 0; i < 40; i++) begin
      bus.i_wr = 1'b1;
      bus.i_data = 8'h80 + 8'(i);
      bus.i_rd = (i > 0);
      step();
      if (i > 0) check("t5_wrap_data", bus.o_data, 8'h80 + i - 1);
      check("t5_wrap_cnt", bus.o_count, 1);
    end
    bus.i_wr = 1'b0;
    bus.i_rd = 1'b0;
    pop();
    check("t5_wrap_last", bus.o_data, 8'hA7);
    check("t5_wrap_empty", bus.o_empty, 1);
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
    bus.i_wr = 1'b1;
    bus.i_data = 8'h63;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    bus.i_wr = 1'b0;
    check("t6_cnt", bus.o_count, 0);
    check("t6_empty", bus.o_empty, 1);
    check("t6_full", bus.o_full, 0);
    check("t6_data", bus.o_data, 8'h00);
    push(8'h55);
    check("t6_cnt1", bus.o_count, 1);
    pop();
    check("t6_fresh", bus.o_data, 8'h55);
    check("t6_empty_end", bus.o_empty, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
